// File: rtl/i2lbs_cascade_scheduler.sv
// Haar-cascade scheduler: walks one shared weak-classifier evaluator through three stages per window.
// Optional statistics counters are built when I2LBS_SCHED_STATS_EN is defined.
module i2lbs_cascade_scheduler #(
    parameter int DATA_WIDTH_12                = 12,
    parameter int ACC_WIDTH                    = 16,
    parameter int NUM_CLASSIFIERS_FIRST_STAGE  = 10,
    parameter int NUM_CLASSIFIERS_SECOND_STAGE = 10,
    parameter int NUM_CLASSIFIERS_THIRD_STAGE  = 10
) (
    input  logic                        clk_fpga,
    input  logic                        reset_fpga,
    input  logic                        win_valid,
    output logic                        win_ready,
    input  logic [DATA_WIDTH_12-1:0]    win_xcoord,
    input  logic [DATA_WIDTH_12-1:0]    win_ycoord,
    output logic                        eval_req,
    output logic [1:0]                  eval_stage,
    output logic [7:0]                  eval_index,
    input  logic                        eval_ack,
    input  logic signed [ACC_WIDTH-1:0] eval_vote,
    input  logic signed [ACC_WIDTH-1:0] stage_threshold,
    output logic                        candidate,
    output logic                        reject,
    output logic [1:0]                  reject_stage,
    output logic [DATA_WIDTH_12-1:0]    o_scale_xcoord,
    output logic [DATA_WIDTH_12-1:0]    o_scale_ycoord,
    output logic                        busy,
    output logic [15:0]                 stat_windows,
    output logic [15:0]                 stat_candidates
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_INDEX_0 = 8'(NUM_CLASSIFIERS_FIRST_STAGE - 1);
    localparam logic [7:0] LAST_INDEX_1 = 8'(NUM_CLASSIFIERS_SECOND_STAGE - 1);
    localparam logic [7:0] LAST_INDEX_2 = 8'(NUM_CLASSIFIERS_THIRD_STAGE - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                      state_q, state_d;
    logic [1:0]                  stage_q, stage_d;
    logic [7:0]                  index_q, index_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH_12-1:0]    xCoord_q, xCoord_d;
    logic [DATA_WIDTH_12-1:0]    yCoord_q, yCoord_d;
    logic                        pass_q, pass_d;

    logic [7:0]                  lastIndex;
    logic signed [ACC_WIDTH:0]   sumWide;
    logic signed [ACC_WIDTH-1:0] accSat;
    logic                        stagePass;
    logic                        accept;

    always_comb begin
        lastIndex = LAST_INDEX_0;
        case (stage_q)
            2'd1:    lastIndex = LAST_INDEX_1;
            2'd2:    lastIndex = LAST_INDEX_2;
            default: lastIndex = LAST_INDEX_0;
        endcase
    end

    // One extra bit of headroom exposes overflow; clamp instead of wrapping.
    assign sumWide = {acc_q[ACC_WIDTH-1], acc_q} + {eval_vote[ACC_WIDTH-1], eval_vote};

    always_comb begin
        accSat = sumWide[ACC_WIDTH-1:0];
        if (sumWide[ACC_WIDTH] != sumWide[ACC_WIDTH-1]) begin
            accSat = sumWide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    assign stagePass = (acc_q >= stage_threshold);
    assign accept    = win_valid & win_ready;

    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            state_q  <= IDLE;
            stage_q  <= 2'd0;
            index_q  <= 8'd0;
            acc_q    <= '0;
            xCoord_q <= '0;
            yCoord_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            index_q  <= index_d;
            acc_q    <= acc_d;
            xCoord_q <= xCoord_d;
            yCoord_q <= yCoord_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        index_d  = index_q;
        acc_d    = acc_q;
        xCoord_d = xCoord_q;
        yCoord_d = yCoord_q;
        pass_d   = pass_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    xCoord_d = win_xcoord;
                    yCoord_d = win_ycoord;
                    stage_d  = 2'd0;
                    index_d  = 8'd0;
                    acc_d    = '0;
                    pass_d   = 1'b0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (eval_ack) begin
                    acc_d = accSat;
                    if (index_q < lastIndex) begin
                        index_d = index_q + 8'd1;
                    end else begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (!stagePass) begin
                    pass_d  = 1'b0;
                    state_d = DONE;
                end else if (stage_q < 2'd2) begin
                    stage_d = stage_q + 2'd1;
                    index_d = 8'd0;
                    acc_d   = '0;
                    state_d = ISSUE;
                end else begin
                    pass_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign win_ready      = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign eval_req       = (state_q == ISSUE);
    assign eval_stage     = stage_q;
    assign eval_index     = index_q;
    assign candidate      = (state_q == DONE) && pass_q;
    assign reject         = (state_q == DONE) && !pass_q;
    assign reject_stage   = reject ? stage_q : 2'd0;
    assign o_scale_xcoord = xCoord_q;
    assign o_scale_ycoord = yCoord_q;

`ifdef I2LBS_SCHED_STATS_EN
    logic [15:0] statWindows_q;
    logic [15:0] statCandidates_q;

    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            statWindows_q    <= 16'd0;
            statCandidates_q <= 16'd0;
        end else begin
            if (accept) begin
                statWindows_q <= statWindows_q + 16'd1;
            end
            if (candidate) begin
                statCandidates_q <= statCandidates_q + 16'd1;
            end
        end
    end

    assign stat_windows    = statWindows_q;
    assign stat_candidates = statCandidates_q;
`else
    logic unusedAccept;
    assign unusedAccept    = accept;
    assign stat_windows    = 16'd0;
    assign stat_candidates = 16'd0;
`endif

endmodule

// File: tb/tb_i2lbs_cascade_scheduler.sv
// Self-checking bench for i2lbs_cascade_scheduler: directed corner windows plus randomized windows
// checked against a stage-by-stage cascade model (request order, latency, result, coordinates, stats).
module tb_i2lbs_cascade_scheduler;

    localparam int DW = 12;
    localparam int AW = 16;

    logic                 clk_fpga    = 1'b0;
    logic                 reset_fpga  = 1'b0;
    logic                 win_valid   = 1'b0;
    logic [DW-1:0]        win_xcoord  = '0;
    logic [DW-1:0]        win_ycoord  = '0;
    logic                 eval_ack    = 1'b0;
    logic signed [AW-1:0] eval_vote   = '0;
    logic signed [AW-1:0] stage_threshold;
    logic                 win_ready, eval_req, candidate, reject, busy;
    logic [1:0]           eval_stage, reject_stage;
    logic [7:0]           eval_index;
    logic [DW-1:0]        o_scale_xcoord, o_scale_ycoord;
    logic [15:0]          stat_windows, stat_candidates;

    // Stimulus tables: the evaluator ROM contents for the current window
    logic signed [AW-1:0] voteTab [3][256];
    logic signed [AW-1:0] thr [3];
    int                   nCls [3] = '{10, 10, 10};

    int          vectorCount = 0;
    int          missCount   = 0;
    logic [15:0] expWindows  = 16'd0;
    logic [15:0] expCands    = 16'd0;

    always #5 clk_fpga = ~clk_fpga;

    assign stage_threshold = (eval_stage == 2'd3) ? '0 : thr[eval_stage];

    i2lbs_cascade_scheduler dut (
        .clk_fpga        (clk_fpga),
        .reset_fpga      (reset_fpga),
        .win_valid       (win_valid),
        .win_ready       (win_ready),
        .win_xcoord      (win_xcoord),
        .win_ycoord      (win_ycoord),
        .eval_req        (eval_req),
        .eval_stage      (eval_stage),
        .eval_index      (eval_index),
        .eval_ack        (eval_ack),
        .eval_vote       (eval_vote),
        .stage_threshold (stage_threshold),
        .candidate       (candidate),
        .reject          (reject),
        .reject_stage    (reject_stage),
        .o_scale_xcoord  (o_scale_xcoord),
        .o_scale_ycoord  (o_scale_ycoord),
        .busy            (busy),
        .stat_windows    (stat_windows),
        .stat_candidates (stat_candidates)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkStats();
`ifdef I2LBS_SCHED_STATS_EN
        checkOutput("stat_windows", stat_windows, expWindows);
        checkOutput("stat_candidates", stat_candidates, expCands);
`else
        checkOutput("stat_tied", {stat_windows, stat_candidates}, 32'd0);
`endif
    endtask

    task automatic checkReset();
        checkOutput("rst_ctrl", {win_ready, eval_req, eval_stage, eval_index, candidate, reject, reject_stage, busy},
                    32'h10000);
        checkOutput("rst_coord", {o_scale_xcoord, o_scale_ycoord}, 32'd0);
        checkStats();
    endtask

    task automatic setUniform(input logic signed [AW-1:0] vote, input logic signed [AW-1:0] t0,
                              input logic signed [AW-1:0] t1, input logic signed [AW-1:0] t2);
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 256; i++) voteTab[s][i] = vote;
        thr[0] = t0;
        thr[1] = t1;
        thr[2] = t2;
    endtask

    // Runs one window with a fixed ack delay; abortAt > 0 pulses reset at that cycle after accept.
    task automatic applyStimulus(input logic [DW-1:0] x, input logic [DW-1:0] y, input int delay, input int abortAt);
        logic [9:0] seq [$];
        logic [9:0] cur;
        int acc, expDone, expRejStage, ptr, waitCnt, cyc, guard;
        bit expPass, finished;

        // Reference cascade: plain integer sums, clamped, compared stage by stage
        seq = {};
        expPass = 1'b1;
        expRejStage = 0;
        expDone = 1;
        for (int s = 0; s < 3; s++) begin
            acc = 0;
            for (int i = 0; i < nCls[s]; i++) begin
                seq.push_back({2'(s), 8'(i)});
                acc = acc + int'(voteTab[s][i]);
                if (acc > 32767) acc = 32767;
                if (acc < -32768) acc = -32768;
            end
            expDone += nCls[s] * (delay + 1) + 1;
            if (acc < int'(thr[s])) begin
                expPass = 1'b0;
                expRejStage = s;
                break;
            end
        end

        guard = 0;
        while (!win_ready && guard < 100) begin
            @(posedge clk_fpga);
            #1;
            guard++;
        end
        checkOutput("ready_before_accept", win_ready, 1);

        win_valid  = 1'b1;
        win_xcoord = x;
        win_ycoord = y;
        @(posedge clk_fpga);
        #1;
        win_valid  = 1'b0;
        win_xcoord = DW'($urandom());
        win_ycoord = DW'($urandom());
        expWindows = expWindows + 16'd1;

        cyc = 1;
        ptr = 0;
        waitCnt = 0;
        finished = 1'b0;
        while (!finished && cyc < 4000) begin
            if (abortAt != 0 && cyc == abortAt) begin
                eval_ack   = 1'b0;
                reset_fpga = 1'b0;
                #1;
                expWindows = 16'd0;
                expCands   = 16'd0;
                checkReset();
                #3 reset_fpga = 1'b1;
                @(posedge clk_fpga);
                #1;
                checkOutput("post_abort", {candidate, reject, busy, win_ready}, 32'h1);
                finished = 1'b1;
                break;
            end
            checkOutput("busy_ready", {busy, win_ready}, 32'h2);
            eval_ack  = 1'b0;
            eval_vote = AW'($urandom());
            if (candidate || reject) begin
                checkOutput("done_cycle", cyc, expDone);
                checkOutput("result", {candidate, reject, reject_stage}, {expPass, !expPass, 2'(expRejStage)});
                checkOutput("coords", {o_scale_xcoord, o_scale_ycoord}, {x, y});
                checkOutput("req_count", ptr, seq.size());
                if (expPass) expCands = expCands + 16'd1;
                finished = 1'b1;
            end else if (eval_req) begin
                if (ptr >= seq.size()) begin
                    checkOutput("req_overrun", ptr, seq.size() - 1);
                end else begin
                    cur = seq[ptr];
                    checkOutput("req_pos", {eval_stage, eval_index}, cur);
                    if (waitCnt == delay) begin
                        eval_ack  = 1'b1;
                        eval_vote = voteTab[cur[9:8]][cur[7:0]];
                        ptr++;
                        waitCnt = 0;
                    end else begin
                        waitCnt++;
                    end
                end
            end else if ($urandom_range(0, 2) == 0) begin
                eval_ack = 1'b1;
            end
            @(posedge clk_fpga);
            #1;
            cyc++;
        end
        eval_ack = 1'b0;
        if (!finished) checkOutput("window_timeout", cyc, expDone);
        if (abortAt == 0) begin
            checkOutput("back_to_idle", {win_ready, busy, candidate, reject}, 32'h8);
            checkStats();
        end
    endtask

    initial begin
        logic signed [AW-1:0] v0, v1, v2;
        int mode, dly;

        repeat (3) @(posedge clk_fpga);
        #1;
        checkReset();
        reset_fpga = 1'b1;
        @(posedge clk_fpga);
        #1;

        setUniform(16'sd1, 16'sd10, 16'sd10, 16'sd10);
        applyStimulus(12'h012, 12'h034, 0, 0);
        setUniform(16'sd1, 16'sd10, 16'sd11, 16'sd10);
        applyStimulus(12'h0A5, 12'h05A, 0, 0);
        setUniform(16'sd1, 16'sd10, 16'sd10, 16'sd10);
        applyStimulus(12'h111, 12'h222, 3, 0);
        setUniform(16'sd1, 16'sd10, 16'sd11, 16'sd10);
        applyStimulus(12'h333, 12'h444, 3, 0);
        setUniform(16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF);
        applyStimulus(12'hFFF, 12'h001, 0, 0);
        setUniform(-16'sh8000, -16'sh8000, -16'sh8000, -16'sh8000);
        applyStimulus(12'h800, 12'h7FF, 1, 0);

        setUniform(16'sd1, 16'sd10, 16'sd10, 16'sd10);
        applyStimulus(12'h0F0, 12'h00F, 0, 15);
        applyStimulus(12'h123, 12'h456, 0, 0);

        for (int w = 0; w < 30; w++) begin
            mode = $urandom_range(0, 4);
            dly  = $urandom_range(0, 3);
            for (int s = 0; s < 3; s++) begin
                for (int i = 0; i < 256; i++) begin
                    v0 = AW'($urandom_range(0, 12)) - 16'sd4;
                    v1 = AW'($urandom());
                    v2 = ($urandom_range(0, 1) == 1) ? 16'sh7FFF : -16'sh8000;
                    voteTab[s][i] = (mode == 0) ? v1 : ((mode == 1) ? v2 : v0);
                end
                thr[s] = (mode <= 1) ? AW'($urandom()) : AW'($urandom_range(0, 30));
            end
            applyStimulus(DW'($urandom()), DW'($urandom()), dly, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
